// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an async square wave over a
// fixed gate window of the system clock; the result reads as edges per gate.
module freq_meter #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clk_100M,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_hz,
  output logic             valid,
  output logic             ovf,
  output logic             gate_active
);

  localparam int unsigned GW =
    (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  if (GATE_CYCLES == 0 || CLK_FREQ == 0) begin : g_bad_param
    $error("freq_meter: GATE_CYCLES and CLK_FREQ must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             edge_pls;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             full;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pls = s2 & ~s3;
  assign full     = &edge_cnt;

  // Saturating count including this cycle's edge, used for the final load too.
  assign cnt_nxt = edge_cnt + CNT_W'(edge_pls & ~full);
  assign sat_nxt = sat | (edge_pls & full);

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      sat         <= 1'b0;
      freq_hz     <= '0;
      ovf         <= 1'b0;
      valid       <= 1'b0;
      gate_active <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (en) begin
            state       <= COUNT;
            gate_active <= 1'b1;
          end
        end
        COUNT: begin
          if (!en) begin
            state       <= IDLE;
            gate_active <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= cnt_nxt;
            sat      <= sat_nxt;
            if (gate_cnt == GATE_LAST) begin
              state       <= DONE;
              gate_active <= 1'b0;
              valid       <= 1'b1;
              freq_hz     <= cnt_nxt;
              ovf         <= sat_nxt;
            end
          end
        end
        DONE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (en) begin
            state       <= COUNT;
            gate_active <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          gate_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: window-arithmetic model of the gate plus directed
// scenarios with hand-computed expectations for freq_meter.
module tb_freq_meter;

  localparam int G    = 100;
  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic         clk_100M = 1'b0;
  logic         rst_n    = 1'b0;
  logic         en       = 1'b0;
  logic         sig_in   = 1'b0;
  logic [W-1:0] freq_hz;
  logic         valid;
  logic         ovf;
  logic         gate_active;

  int n_chk  = 0;
  int n_fail = 0;
  int half   = 0;
  int ph     = 0;

  freq_meter #(
    .CLK_FREQ   (100_000_000),
    .GATE_CYCLES(G),
    .CNT_W      (W)
  ) dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .en         (en),
    .sig_in     (sig_in),
    .freq_hz    (freq_hz),
    .valid      (valid),
    .ovf        (ovf),
    .gate_active(gate_active)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: a gate is the G cycles starting at 'start'; the cycle after
  // it is the result cycle. A sig_in rise driven in cycle k is an edge
  // in cycle k+2; a result counts edges inside the gate window.
  int cyc     = 0;
  int start   = -1;
  int m_freq  = 0;
  int k       = 0;
  bit m_ovf   = 1'b0;
  bit m_vld   = 1'b0;
  bit m_act   = 1'b0;
  bit prev_s  = 1'b0;
  int edges[$];

  always @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      start  = -1;
      m_freq = 0;
      m_ovf  = 1'b0;
      m_vld  = 1'b0;
      m_act  = 1'b0;
      prev_s = 1'b0;
      edges.delete();
    end else begin
      cyc++;
      if (sig_in && !prev_s) edges.push_back(cyc + 1);
      prev_s = sig_in;
      if (start >= 0 && cyc - 1 - start < G) begin
        if (!en) start = -1;
      end else if (start >= 0) begin
        start = en ? cyc : -1;
      end else if (en) begin
        start = cyc;
      end
      m_act = (start >= 0) && (cyc - start < G);
      m_vld = (start >= 0) && (cyc - start == G);
      if (m_vld) begin
        k = 0;
        foreach (edges[i])
          if (edges[i] >= start && edges[i] < cyc) k++;
        m_freq = (k > MAXC) ? MAXC : k;
        m_ovf  = (k > MAXC);
        while (edges.size() > 0 && edges[0] < cyc)
          void'(edges.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk_100M);
    check("freq_hz", int'(freq_hz), m_freq);
    check("valid", int'(valid), int'(m_vld));
    check("ovf", int'(ovf), int'(m_ovf));
    check("gate_active", int'(gate_active), int'(m_act));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_100M);
      if (half > 0) begin
        ph++;
        if (ph >= half) begin
          ph     = 0;
          sig_in = ~sig_in;
        end
      end
    end
  endtask

  task automatic wait_valid(input int limit, output int took);
    took = 0;
    do begin
      step(1);
      took++;
    end while (!valid && took < limit);
    check("valid_within_bound", int'(valid), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int nv;
    step(3);
    check("rst_freq", int'(freq_hz), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_gate", int'(gate_active), 0);
    rst_n = 1'b1;
    step(2);
    check("idle_gate", int'(gate_active), 0);

    half = 5;
    en   = 1'b1;
    wait_valid(300, t);
    check("first_latency", t, G + 1);
    wait_valid(150, t);
    check("basic_period", t, G + 1);
    check("basic_freq", int'(freq_hz), 10);
    check("basic_ovf", int'(ovf), 0);
    wait_valid(150, t);
    check("basic_freq2", int'(freq_hz), 10);

    half   = 0;
    sig_in = 1'b0;
    repeat (3) wait_valid(150, t);
    check("dc_low", int'(freq_hz), 0);
    sig_in = 1'b1;
    repeat (3) wait_valid(150, t);
    check("dc_high", int'(freq_hz), 0);

    half = 2;
    repeat (3) wait_valid(150, t);
    check("sat_freq", int'(freq_hz), 15);
    check("sat_ovf", int'(ovf), 1);

    step(30);
    @(posedge clk_100M);
    #3 rst_n = 1'b0;
    #1;
    check("arst_freq", int'(freq_hz), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_ovf", int'(ovf), 0);
    check("arst_gate", int'(gate_active), 0);
    step(3);
    rst_n = 1'b1;
    wait_valid(300, t);
    check("arst_latency", t, G + 1);
    check("arst_sat_freq", int'(freq_hz), 15);

    half = 10;
    repeat (3) wait_valid(150, t);
    check("p20_freq", int'(freq_hz), 5);
    check("p20_ovf", int'(ovf), 0);

    wait_valid(150, t);
    step(50);
    en = 1'b0;
    step(1);
    check("abort_gate", int'(gate_active), 0);
    nv = 0;
    repeat (150) begin
      step(1);
      if (valid) nv++;
    end
    check("abort_no_valid", nv, 0);
    check("abort_hold_freq", int'(freq_hz), 5);
    en = 1'b1;
    wait_valid(300, t);
    check("abort_restart", t, G + 1);
    check("abort_new_freq", int'(freq_hz), 5);

    half   = 0;
    sig_in = 1'b0;
    repeat (2) wait_valid(150, t);
    step(98);
    sig_in = 1'b1;
    step(1);
    sig_in = 1'b0;
    wait_valid(150, t);
    check("last_cycle_at", t, 2);
    check("last_cycle_freq", int'(freq_hz), 1);
    step(99);
    sig_in = 1'b1;
    step(1);
    sig_in = 1'b0;
    wait_valid(150, t);
    check("dead_cycle_at", t, 1);
    check("dead_before", int'(freq_hz), 0);
    wait_valid(150, t);
    check("dead_after", int'(freq_hz), 0);

    en = 1'b0;
    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
